morphle_config_loader: RTL and testbench
========================================

# morphle_config_loader

Wishbone-driven configuration sequencer for a Morphle Logic yblock, replacing bit-banged logic-analyzer control of `reset`/`confclk`/`cbitin`. Software pushes BLOCKWIDTH-bit configuration rows into a write FIFO. The loader shifts each row into the block with a programmable `confclk` strobe, counts strobes to CHAIN_DEPTH and optionally releases the block from reset. It sits in the user project between the Wishbone bus and the yblock's configuration ports.

## Interface
- BLOCKWIDTH, 16, width of `cbitin`/`cbitout` and of each FIFO entry
- CHAIN_DEPTH, 48, strobes needed for a full block load; 1..65535
- FIFO_DEPTH, 8, entries in the write FIFO and in the readback FIFO; power of two, 2..128
- SETUP_CYC, 2, cycles `cbitin` is stable before `confclk` rises; >=1
- PULSE_CYC, 2, cycles `confclk` is high; >=1
- HOLD_CYC, 2, cycles `cbitin` is held after `confclk` falls; >=1
- wb_clk_i  in  1  sole clock; all logic is on its rising edge
- wb_rst_n_i  in  1  asynchronous active-low reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle and write enable
- wbs_sel_i  in  4  byte selects; ignored, every access is a full word
- wbs_adr_i  in  32  byte address; only [3:2] is decoded
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- cfg_reset  out  1  drives yblock `reset`; active high
- confclk  out  1  drives yblock `confclk`
- cbitin  out  BLOCKWIDTH  drives yblock `cbitin`
- cbitout  in  BLOCKWIDTH  from yblock `cbitout`

## Operation
- Registers, selected by word address:
  - 0 CTRL (R/W): bit0 start, self-clearing and reads 0; bit1 blk_reset; bit2 auto_release; bit3 clear, self-clearing and reads 0.
  - 1 STATUS (RO): bit0 busy; bit1 done; bit2 wfull; bit3 wempty; bit4 woverflow; bit5 runderflow; bit6 roverflow; [15:8] write-FIFO level; [31:16] strobe count.
  - 2 WDATA (WO): pushes wbs_dat_i[BLOCKWIDTH-1:0] into the write FIFO. Reads return 0.
  - 3 RDATA (RO): pops the readback FIFO and returns the popped entry zero-extended to 32 bits.
- `cfg_reset` equals CTRL.blk_reset.
- Writing 1 to start while busy is ignored. Writing 1 to start when idle clears done and the strobe count, then enters LOAD.
- FSM states and transitions:
  - IDLE -> LOAD on start.
  - LOAD: if the write FIFO is empty, stay in LOAD with busy=1 (stall). Otherwise pop one entry into `cbitin` and go to SETUP.
  - SETUP: lasts SETUP_CYC cycles, then PULSE.
  - PULSE: `confclk`=1 for PULSE_CYC cycles. The strobe count increments on PULSE entry. Then HOLD.
  - HOLD: lasts HOLD_CYC cycles. If count == CHAIN_DEPTH go to DONE, else go to LOAD.
  - DONE: set done. If auto_release=1, clear blk_reset. Go to IDLE.
- Writing CTRL.clear in any state:
  - returns the FSM to IDLE and drops `confclk` to 0 the next cycle;
  - flushes both FIFOs;
  - zeroes the strobe count and all sticky flags.
- A push to a full write FIFO is dropped and sets woverflow. Fullness is evaluated before any pop in the same cycle.
- A read of an empty readback FIFO returns 0 and sets runderflow.
- A push and a pop in the same cycle on a non-full, non-empty FIFO leaves the level unchanged.
- Sticky flags clear only on clear or reset.

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, confclk=0, cbitin=0, cfg_reset=1, FSM=IDLE, count=0, FIFOs empty, all flags 0.
- Wishbone:
  - wbs_ack_o asserts 1 cycle after a cycle with stb&cyc&!ack, for exactly 1 cycle.
  - There are no wait states. Register side effects (push, pop, CTRL update) take place on the acknowledging edge.
  - wbs_dat_o is valid in the ack cycle and is 0 otherwise.
- Strobe period with a non-empty FIFO is 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles (7 with defaults).
- `cbitin` changes only on LOAD exit. `confclk` is never high in LOAD or SETUP.
- busy falls the cycle DONE is entered. done is set, and cfg_reset falls (if auto_release), on the cycle after the last HOLD cycle.

## Configuration
- MORPHLE_READBACK_EN defined:
  - `cbitout` is sampled in the last SETUP cycle and pushed into the readback FIFO.
  - If that FIFO is full, the sample is dropped and roverflow is set.
- Not defined:
  - the readback FIFO is absent;
  - RDATA reads 0 with no side effects;
  - STATUS bits 5 and 6 read 0.

## Test plan
- Reset: assert wb_rst_n_i=0 mid-PULSE -> confclk=0 and cfg_reset=1 immediately; STATUS reads 0x0000_0008.
- CHAIN_DEPTH=4: push 0x0001..0x0004, write CTRL=0x5 (start, auto_release) -> exactly 4 confclk pulses, each PULSE_CYC high, with cbitin=1,2,3,4 respectively. Then done=1, cfg_reset=0, count=4.
- Stall: push 2 words, start (CHAIN_DEPTH=4) -> 2 pulses, then busy=1 stalled in LOAD. Push 2 more -> pulses 3 and 4, then done.
- Overflow: with FIFO_DEPTH=8 and the loader idle, push 9 words -> level=8, woverflow=1; the 9th word is never strobed.
- Clear mid-load: write CTRL.clear during PULSE -> confclk=0 on the next cycle, busy=0, level=0, count=0.
- Readback (macro on): with the yblock modelled as a shift chain of CHAIN_DEPTH=2, load 0xAAAA, 0x5555 and repeat -> RDATA returns the prior contents in order. A read after the FIFO empties returns 0 and sets runderflow.

Source files
------------

// File: rtl/morphle_config_loader.sv
// Wishbone-driven configuration sequencer for a Morphle Logic yblock.
// Optional readback FIFO enabled by defining MORPHLE_READBACK_EN.
`timescale 1ns/1ps
module morphle_config_loader #(
  parameter int BLOCKWIDTH  = 16,
  parameter int CHAIN_DEPTH = 48,
  parameter int FIFO_DEPTH  = 8,
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 2,
  parameter int HOLD_CYC    = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  cfg_reset,
  output logic                  confclk,
  output logic [BLOCKWIDTH-1:0] cbitin,
  input  logic [BLOCKWIDTH-1:0] cbitout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FIFO_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYC - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] CHAIN_LAST = 16'(CHAIN_DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_PULSE = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]  state_reg, state_next;
  logic [15:0] timer_reg, timer_next;
  logic [15:0] count_reg;
  logic        done_reg, blk_reset_reg, auto_release_reg, woverflow_reg;
  logic        confclk_reg, ack_reg;
  logic [31:0] dat_o_reg, rd_data;
  logic [BLOCKWIDTH-1:0] cbitin_reg;

  logic [BLOCKWIDTH-1:0] wmem [FIFO_DEPTH];
  logic [AW-1:0] wwr_ptr_reg, wrd_ptr_reg;
  logic [AW:0]   wlevel_reg;

  logic       wb_access, wb_wr, wb_rd;
  logic [1:0] reg_sel;
  logic       ctrl_wr, start_req, clear_req, start_ok, wpush, wpush_ok, wpop;
  logic       wfull, wempty, busy, enter_done;
  logic       runderflow, roverflow;
  logic [BLOCKWIDTH-1:0] rdata;
  logic       unused_bits;

  // Every side effect happens on the edge that raises ack, so there are no wait states.
  assign wb_access = wbs_stb_i & wbs_cyc_i & ~ack_reg;
  assign wb_wr     = wb_access & wbs_we_i;
  assign wb_rd     = wb_access & ~wbs_we_i;
  assign reg_sel   = wbs_adr_i[3:2];
  assign ctrl_wr   = wb_wr && (reg_sel == 2'd0);
  assign start_req = ctrl_wr & wbs_dat_i[0];
  assign clear_req = ctrl_wr & wbs_dat_i[3];
  assign wpush     = wb_wr && (reg_sel == 2'd2);

  assign wfull    = (wlevel_reg == FIFO_FULL);
  assign wempty   = (wlevel_reg == '0);
  assign wpush_ok = wpush & ~wfull;
  assign wpop     = (state_reg == ST_LOAD) & ~wempty;
  assign busy     = (state_reg == ST_LOAD) || (state_reg == ST_SETUP) ||
                    (state_reg == ST_PULSE) || (state_reg == ST_HOLD);
  assign start_ok = start_req & ~busy & ~clear_req;

  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i, cbitout};

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg + 16'd1;
    case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
        if (start_req) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        timer_next = '0;
        if (!wempty) state_next = ST_SETUP;
      end
      ST_SETUP: if (timer_reg == SETUP_LAST) begin
        state_next = ST_PULSE;
        timer_next = '0;
      end
      ST_PULSE: if (timer_reg == PULSE_LAST) begin
        state_next = ST_HOLD;
        timer_next = '0;
      end
      ST_HOLD: if (timer_reg == HOLD_LAST) begin
        state_next = (count_reg == CHAIN_LAST) ? ST_DONE : ST_LOAD;
        timer_next = '0;
      end
      ST_DONE: begin
        timer_next = '0;
        state_next = start_ok ? ST_LOAD : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        timer_next = '0;
      end
    endcase
    if (clear_req) begin
      state_next = ST_IDLE;
      timer_next = '0;
    end
  end

  assign enter_done = (state_reg == ST_HOLD) && (state_next == ST_DONE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_reg        <= ST_IDLE;
      timer_reg        <= '0;
      confclk_reg      <= 1'b0;
      count_reg        <= '0;
      done_reg         <= 1'b0;
      blk_reset_reg    <= 1'b1;
      auto_release_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      confclk_reg <= (state_next == ST_PULSE);
      if (ctrl_wr) begin
        blk_reset_reg    <= wbs_dat_i[1];
        auto_release_reg <= wbs_dat_i[2];
      end
      if (clear_req || start_ok) begin
        count_reg <= '0;
        done_reg  <= 1'b0;
      end else begin
        if (state_reg == ST_SETUP && state_next == ST_PULSE) count_reg <= count_reg + 16'd1;
        if (enter_done) done_reg <= 1'b1;
      end
      if (enter_done && auto_release_reg) blk_reset_reg <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wpush_ok) wmem[wwr_ptr_reg] <= wbs_dat_i[BLOCKWIDTH-1:0];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wwr_ptr_reg   <= '0;
      wrd_ptr_reg   <= '0;
      wlevel_reg    <= '0;
      woverflow_reg <= 1'b0;
      cbitin_reg    <= '0;
    end else if (clear_req) begin
      wwr_ptr_reg   <= '0;
      wrd_ptr_reg   <= '0;
      wlevel_reg    <= '0;
      woverflow_reg <= 1'b0;
    end else begin
      if (wpush_ok) wwr_ptr_reg <= wwr_ptr_reg + 1'b1;
      if (wpop) begin
        wrd_ptr_reg <= wrd_ptr_reg + 1'b1;
        cbitin_reg  <= wmem[wrd_ptr_reg];
      end
      wlevel_reg <= wlevel_reg + (AW+1)'(wpush_ok) - (AW+1)'(wpop);
      if (wpush && wfull) woverflow_reg <= 1'b1;
    end
  end

`ifdef MORPHLE_READBACK_EN
  logic [BLOCKWIDTH-1:0] rmem [FIFO_DEPTH];
  logic [AW-1:0] rwr_ptr_reg, rrd_ptr_reg;
  logic [AW:0]   rlevel_reg;
  logic          runderflow_reg, roverflow_reg;
  logic          rpush, rpop, rfull, rempty, rpush_ok, rpop_ok;

  // The yblock output is captured just before the strobe that shifts it away.
  assign rpush    = (state_reg == ST_SETUP) && (timer_reg == SETUP_LAST);
  assign rpop     = wb_rd && (reg_sel == 2'd3);
  assign rfull    = (rlevel_reg == FIFO_FULL);
  assign rempty   = (rlevel_reg == '0);
  assign rpush_ok = rpush & ~rfull;
  assign rpop_ok  = rpop & ~rempty;
  assign rdata    = rempty ? '0 : rmem[rrd_ptr_reg];
  assign runderflow = runderflow_reg;
  assign roverflow  = roverflow_reg;

  always_ff @(posedge wb_clk_i) begin
    if (rpush_ok) rmem[rwr_ptr_reg] <= cbitout;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rwr_ptr_reg    <= '0;
      rrd_ptr_reg    <= '0;
      rlevel_reg     <= '0;
      runderflow_reg <= 1'b0;
      roverflow_reg  <= 1'b0;
    end else if (clear_req) begin
      rwr_ptr_reg    <= '0;
      rrd_ptr_reg    <= '0;
      rlevel_reg     <= '0;
      runderflow_reg <= 1'b0;
      roverflow_reg  <= 1'b0;
    end else begin
      if (rpush_ok) rwr_ptr_reg <= rwr_ptr_reg + 1'b1;
      if (rpop_ok)  rrd_ptr_reg <= rrd_ptr_reg + 1'b1;
      rlevel_reg <= rlevel_reg + (AW+1)'(rpush_ok) - (AW+1)'(rpop_ok);
      if (rpush && rfull)  roverflow_reg  <= 1'b1;
      if (rpop && rempty)  runderflow_reg <= 1'b1;
    end
  end
`else
  assign rdata      = '0;
  assign runderflow = 1'b0;
  assign roverflow  = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      2'd0: rd_data = {29'd0, auto_release_reg, blk_reset_reg, 1'b0};
      2'd1: rd_data = {count_reg, 8'(wlevel_reg), 1'b0, roverflow, runderflow,
                       woverflow_reg, wempty, wfull, done_reg, busy};
      2'd3: rd_data = 32'(rdata);
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_reg   <= 1'b0;
      dat_o_reg <= '0;
    end else begin
      ack_reg   <= wb_access;
      dat_o_reg <= wb_rd ? rd_data : '0;
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_o_reg;
  assign cfg_reset = blk_reset_reg;
  assign confclk   = confclk_reg;
  assign cbitin    = cbitin_reg;

endmodule

// File: tb/tb_morphle_config_loader.sv
// Self-checking bench for morphle_config_loader: scoreboarded strobes and readback,
// with a behavioural yblock shift chain; follows MORPHLE_READBACK_EN like the design.
`timescale 1ns/1ps
module tb_morphle_config_loader;
  localparam int BW = 16, CD = 4, FD = 8, SC = 2, PC = 2, HC = 2;
  localparam int PERIOD = 1 + SC + PC + HC;
`ifdef MORPHLE_READBACK_EN
  localparam logic [31:0] RB_OVF = 32'h40;
`else
  localparam logic [31:0] RB_OVF = 32'h0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, stb = 1'b0, cyc_i = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, wdat = '0, rdat;
  logic        ack, cfg_reset, confclk;
  logic [BW-1:0] cbitin, cbitout;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  morphle_config_loader #(
    .BLOCKWIDTH(BW), .CHAIN_DEPTH(CD), .FIFO_DEPTH(FD),
    .SETUP_CYC(SC), .PULSE_CYC(PC), .HOLD_CYC(HC)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc_i),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat), .cfg_reset(cfg_reset), .confclk(confclk),
    .cbitin(cbitin), .cbitout(cbitout)
  );

  // Behavioural yblock: a CD-deep shift chain clocked by confclk.
  logic [BW-1:0] chain [CD];
  initial for (int i = 0; i < CD; i++) chain[i] = '0;
  always @(posedge confclk) begin
    for (int i = CD - 1; i > 0; i--) chain[i] <= chain[i-1];
    chain[0] <= cbitin;
  end
  assign cbitout = chain[CD-1];

  typedef struct { logic [BW-1:0] data; int width; int rise; } pulse_t;
  pulse_t        obs_q[$];
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] rb_q[$];

  int cyc_cnt = 0, width_r = 0, rise_r = 0, last_fall = 0, rst_fall = 0;
  logic prev_cc = 1'b0, prev_rst = 1'b1;
  logic [BW-1:0] cb_r = '0;
  always @(negedge clk) begin
    cyc_cnt  <= cyc_cnt + 1;
    prev_cc  <= confclk;
    prev_rst <= cfg_reset;
    if (confclk && !prev_cc) begin
      width_r <= 1; rise_r <= cyc_cnt; cb_r <= cbitin;
    end else if (confclk) begin
      width_r <= width_r + 1;
    end else if (prev_cc) begin
      obs_q.push_back(pulse_t'{cb_r, width_r, rise_r});
      last_fall <= cyc_cnt;
    end
    if (prev_rst && !cfg_reset) rst_fall <= cyc_cnt;
  end

  task automatic wb_xfer(input logic w, input int word, input logic [31:0] d, output logic [31:0] q);
    bit got;
    got = 0; q = '0;
    stb = 1'b1; cyc_i = 1'b1; we = w; adr = 32'(word * 4); wdat = d;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1; q = rdat; break; end
    end
    stb = 1'b0; cyc_i = 1'b0; we = 1'b0;
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL wb_ack: ack=%b required 1 within 6 cycles (adr word %0d)", ack, word);
    end
    $display("wb %s word=%0d data=%08h", w ? "wr" : "rd", word, w ? d : q);
  endtask

  task automatic wb_write(input int word, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, word, d, dummy);
  endtask

  task automatic wb_read(input int word, output logic [31:0] q);
    wb_xfer(1'b0, word, 32'h0, q);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      wb_read(1, s);
      if (s[1]) begin ok = 1; break; end
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s_done_wait: status=%08h required done=1 within poll budget", tag, s);
    end
  endtask

  task automatic test_reset();
    logic [31:0] q;
    wb_read(1, q);
    compared++; if (q !== 32'h8) begin mismatched++; $display("FAIL reset_status: got %08h required 00000008", q); end
    wb_read(0, q);
    compared++; if (q !== 32'h2) begin mismatched++; $display("FAIL reset_ctrl: got %08h required 00000002", q); end
    compared++; if (confclk !== 1'b0 || cbitin !== '0 || cfg_reset !== 1'b1) begin
      mismatched++; $display("FAIL reset_outputs: confclk=%b cbitin=%h cfg_reset=%b required 0/0000/1", confclk, cbitin, cfg_reset);
    end
    wb_write(2, 32'h00F0);
    wb_write(0, 32'h1);
    for (int i = 0; i < 40 && !confclk; i++) begin @(posedge clk); #1; end
    compared++; if (confclk !== 1'b1) begin mismatched++; $display("FAIL reset_pulse_wait: confclk=%b required 1", confclk); end
    #2 rst_n = 1'b0;
    #1;
    compared++; if (confclk !== 1'b0 || cfg_reset !== 1'b1) begin
      mismatched++; $display("FAIL reset_async: confclk=%b cfg_reset=%b required 0/1", confclk, cfg_reset);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    wb_read(1, q);
    compared++; if (q !== 32'h8) begin mismatched++; $display("FAIL reset_status_after: got %08h required 00000008", q); end
    obs_q.delete();
  endtask

  task automatic test_load();
    logic [31:0] q;
    pulse_t p;
    logic [BW-1:0] e;
    int prev_rise;
    for (int i = 1; i <= 4; i++) begin
      wb_write(2, 32'(i));
      exp_q.push_back(BW'(i));
    end
    wb_read(1, q);
    compared++; if (q !== 32'h0000_0400) begin mismatched++; $display("FAIL load_level: status=%08h required 00000400", q); end
    wb_write(0, 32'h7);
    compared++; if (cfg_reset !== 1'b1) begin mismatched++; $display("FAIL load_cfg_reset_hold: got %b required 1", cfg_reset); end
    wait_done("load");
    wb_read(1, q);
    compared++; if (q !== 32'h0004_000A) begin mismatched++; $display("FAIL load_status: got %08h required 0004000a", q); end
    compared++; if (cfg_reset !== 1'b0) begin mismatched++; $display("FAIL load_release: cfg_reset=%b required 0", cfg_reset); end
    compared++; if (rst_fall - last_fall != HC) begin
      mismatched++; $display("FAIL load_release_timing: %0d cycles after last confclk fall, required %0d", rst_fall - last_fall, HC);
    end
    compared++; if (obs_q.size() != 4) begin mismatched++; $display("FAIL load_pulse_count: got %0d required 4", obs_q.size()); end
    prev_rise = 0;
    for (int i = 0; i < 4 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      p = obs_q.pop_front(); e = exp_q.pop_front();
      compared++; if (p.data !== e) begin mismatched++; $display("FAIL load_cbitin[%0d]: got %h required %h", i, p.data, e); end
      compared++; if (p.width != PC) begin mismatched++; $display("FAIL load_width[%0d]: got %0d required %0d", i, p.width, PC); end
      if (i > 0) begin
        compared++; if (p.rise - prev_rise != PERIOD) begin
          mismatched++; $display("FAIL load_period[%0d]: got %0d required %0d", i, p.rise - prev_rise, PERIOD);
        end
      end
      prev_rise = p.rise;
    end
  endtask

  task automatic test_stall();
    logic [31:0] q;
    pulse_t p;
    logic [BW-1:0] e;
    wb_write(2, 32'h11); exp_q.push_back(16'h11);
    wb_write(2, 32'h22); exp_q.push_back(16'h22);
    wb_write(0, 32'h3);
    repeat (5 * PERIOD) @(posedge clk); #1;
    compared++; if (obs_q.size() != 2) begin mismatched++; $display("FAIL stall_pulse_count: got %0d required 2", obs_q.size()); end
    wb_read(1, q);
    compared++; if (q !== 32'h0002_0009) begin mismatched++; $display("FAIL stall_status: got %08h required 00020009", q); end
    wb_write(2, 32'h33); exp_q.push_back(16'h33);
    wb_write(2, 32'h44); exp_q.push_back(16'h44);
    wait_done("stall");
    wb_read(1, q);
    compared++; if (q !== 32'h0004_000A) begin mismatched++; $display("FAIL stall_status_done: got %08h required 0004000a", q); end
    compared++; if (cfg_reset !== 1'b1) begin mismatched++; $display("FAIL stall_no_release: cfg_reset=%b required 1", cfg_reset); end
    compared++; if (obs_q.size() != 4) begin mismatched++; $display("FAIL stall_total_pulses: got %0d required 4", obs_q.size()); end
    for (int i = 0; i < 4 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      p = obs_q.pop_front(); e = exp_q.pop_front();
      compared++; if (p.data !== e) begin mismatched++; $display("FAIL stall_cbitin[%0d]: got %h required %h", i, p.data, e); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] q;
    pulse_t p;
    logic [BW-1:0] e;
    for (int i = 0; i < FD + 1; i++) begin
      wb_write(2, 32'h0100 + 32'(i));
      if (i < FD) exp_q.push_back(BW'(16'h0100 + i));
    end
    wb_read(1, q);
    compared++; if (q !== 32'h0004_0816) begin mismatched++; $display("FAIL ovf_status: got %08h required 00040816", q); end
    wb_write(0, 32'h3);
    wait_done("ovf_first");
    wb_write(0, 32'h3);
    wait_done("ovf_second");
    wb_read(1, q);
    compared++; if (q !== (32'h0004_001A | RB_OVF)) begin
      mismatched++; $display("FAIL ovf_status_after: got %08h required %08h", q, 32'h0004_001A | RB_OVF);
    end
    compared++; if (obs_q.size() != FD) begin mismatched++; $display("FAIL ovf_pulse_count: got %0d required %0d", obs_q.size(), FD); end
    for (int i = 0; i < FD && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      p = obs_q.pop_front(); e = exp_q.pop_front();
      compared++; if (p.data !== e) begin mismatched++; $display("FAIL ovf_cbitin[%0d]: got %h required %h", i, p.data, e); end
    end
  endtask

  task automatic test_clear();
    logic [31:0] q;
    for (int i = 0; i < 4; i++) wb_write(2, 32'h51 + 32'(i));
    wb_write(0, 32'h3);
    for (int i = 0; i < 40 && !confclk; i++) begin @(posedge clk); #1; end
    compared++; if (confclk !== 1'b1) begin mismatched++; $display("FAIL clear_pulse_wait: confclk=%b required 1", confclk); end
    wb_write(0, 32'hA);
    compared++; if (confclk !== 1'b0) begin mismatched++; $display("FAIL clear_confclk: got %b required 0", confclk); end
    wb_read(1, q);
    compared++; if (q !== 32'h8) begin mismatched++; $display("FAIL clear_status: got %08h required 00000008", q); end
    repeat (3) @(posedge clk); #1;
    obs_q.delete();
    exp_q.delete();
    repeat (4 * PERIOD) @(posedge clk); #1;
    compared++; if (obs_q.size() != 0 || confclk !== 1'b0) begin
      mismatched++; $display("FAIL clear_quiet: %0d pulses confclk=%b required 0 pulses, confclk 0", obs_q.size(), confclk);
    end
  endtask

  task automatic test_readback();
    logic [31:0] q;
`ifdef MORPHLE_READBACK_EN
    logic [BW-1:0] words [4];
    logic [BW-1:0] soft [CD];
    logic [BW-1:0] e;
    words[0] = 16'hAAAA; words[1] = 16'h5555; words[2] = 16'hAAAA; words[3] = 16'h5555;
    for (int i = 0; i < CD; i++) soft[i] = '0;
    wb_write(0, 32'hA);
    for (int i = 0; i < 4; i++) begin
      wb_write(2, 32'(words[i]));
      for (int k = CD - 1; k > 0; k--) soft[k] = soft[k-1];
      soft[0] = words[i];
    end
    wb_write(0, 32'h3);
    wait_done("rb_prime");
    for (int i = 0; i < 4; i++) wb_read(3, q);
    for (int i = 0; i < 4; i++) begin
      wb_write(2, 32'(words[i]));
      rb_q.push_back(soft[CD-1]);
      for (int k = CD - 1; k > 0; k--) soft[k] = soft[k-1];
      soft[0] = words[i];
    end
    wb_write(0, 32'h3);
    wait_done("rb_load");
    for (int i = 0; i < 4 && rb_q.size() > 0; i++) begin
      e = rb_q.pop_front();
      wb_read(3, q);
      compared++; if (q !== 32'(e)) begin mismatched++; $display("FAIL rb_data[%0d]: got %08h required %08h", i, q, 32'(e)); end
    end
    wb_read(3, q);
    compared++; if (q !== 32'h0) begin mismatched++; $display("FAIL rb_empty_read: got %08h required 00000000", q); end
    wb_read(1, q);
    compared++; if (q[6:5] !== 2'b01) begin mismatched++; $display("FAIL rb_underflow: status[6:5]=%b required 01", q[6:5]); end
`else
    wb_read(3, q);
    compared++; if (q !== 32'h0) begin mismatched++; $display("FAIL rb_absent_read: got %08h required 00000000", q); end
    wb_read(1, q);
    compared++; if (q[6:5] !== 2'b00) begin mismatched++; $display("FAIL rb_absent_flags: status[6:5]=%b required 00", q[6:5]); end
`endif
    obs_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    test_reset();
    test_load();
    test_stall();
    test_overflow();
    test_clear();
    test_readback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
